// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit carry-chained slice, LSB digit first.
// N = WIDTH/DIGIT run cycles per operation; start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Ai,
  input  logic [WIDTH-1:0] Bi,
  input  logic             Ci,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] So,
  output logic             Co,
  output logic             Ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [DIGIT:0]   slice_t;
  typedef logic [CntW-1:0]  cnt_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;
  word_t  a_q, a_d, b_q, b_d, res_q, res_d, so_q, so_d;
  cnt_t   cnt_q, cnt_d;
  logic   c_q, c_d, co_q, co_d, ovf_q, ovf_d;
  logic   a_msb_q, a_msb_d, b_msb_q, b_msb_d;

  logic   accept, last;
  slice_t slice_sum;
  word_t  res_next, b_eff;

  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == cnt_t'(N - 1));
  assign b_eff  = Sub ? ~Bi : Bi;

  always_comb begin
    slice_sum = slice_t'(a_q[DIGIT-1:0]) + slice_t'(b_q[DIGIT-1:0]) + slice_t'(c_q);
    // New digit enters from the MSB side; after N shifts the word is aligned.
    res_next  = (res_q >> DIGIT) | (word_t'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      so_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      so_q    <= so_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    so_d    = so_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = Ai;
      b_d     = b_eff;
      c_d     = Sub ? ~Ci : Ci;
      res_d   = '0;
      cnt_d   = '0;
      a_msb_d = Ai[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end else if (state_q == StRun) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      c_d   = slice_sum[DIGIT];
      res_d = res_next;
      cnt_d = cnt_q + cnt_t'(1);
      if (last) begin
        so_d  = res_next;
        co_d  = slice_sum[DIGIT];
        ovf_d = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    So   = so_q;
    Co   = co_q;
    Ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8/1 instance and a 16/4 instance.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, ci8, sub8, busy8, done8, co8, ovf8;
  logic [7:0]  a8, b8, so8;
  logic        start16, ci16, sub16, busy16, done16, co16, ovf16;
  logic [15:0] a16, b16, so16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .Ai(a8), .Bi(b8), .Ci(ci8), .Sub(sub8),
    .busy(busy8), .done(done8), .So(so8), .Co(co8), .Ovf(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .Ai(a16), .Bi(b16), .Ci(ci16), .Sub(sub16),
    .busy(busy16), .done(done16), .So(so16), .Co(co16), .Ovf(ovf16)
  );

  typedef struct {
    logic [15:0] so;
    logic        co;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sub, input logic [7:0] so, input logic co,
                        input logic ovf);
    a8 = a; b8 = b; ci8 = ci; sub8 = sub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back('{so: {8'h00, so}, co: co, ovf: ovf, acc: cyc});
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sub, input logic [15:0] so, input logic co,
                         input logic ovf);
    a16 = a; b16 = b; ci16 = ci; sub16 = sub; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    q16.push_back('{so: so, co: co, ovf: ovf, acc: cyc});
  endtask

  task automatic drain(input bit wide);
    for (int i = 0; i < 200; i++) begin
      if ((wide ? q16.size() : q8.size()) == 0) break;
      @(posedge clk); #1;
    end
    chk(wide ? "drain16" : "drain8", wide ? q16.size() : q8.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) chk("spurious_done8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("so8", so8, e8.so[7:0]);
        chk("co8", co8, e8.co);
        chk("ovf8", ovf8, e8.ovf);
        chk("latency8", cyc - e8.acc, 8);
        chk("busy_at_done8", busy8, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done16) begin
      if (q16.size() == 0) chk("spurious_done16", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("so16", so16, e16.so);
        chk("co16", co16, e16.co);
        chk("ovf16", ovf16, e16.ovf);
        chk("latency16", cyc - e16.acc, 4);
        chk("busy_at_done16", busy16, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0;
    start16 = 0; a16 = 0; b16 = 0; ci16 = 0; sub16 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_so8", so8, 0);
    chk("rst_co8", co8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_so16", so16, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3C + 45: signed overflow into 81, busy for exactly 8 cycles.
    issue8(8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
    nbusy = 0;
    repeat (8) begin
      @(negedge clk);
      nbusy += busy8;
    end
    chk("busy_cycles8", nbusy, 8);
    @(negedge clk);
    chk("busy_drop8", busy8, 0);
    @(posedge clk); #1;
    drain(1'b0);

    // Subtract: borrow case, then overflow case.
    issue8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    drain(1'b0);
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain(1'b0);
    issue8(8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
    drain(1'b0);

    // Carry-in wraps FF to 00; operand changes and start mid-RUN must be ignored.
    issue8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'h55; b8 = 8'hAA; ci8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain(1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("hold_so8", so8, 8'h00);
    chk("hold_co8", co8, 1'b1);
    chk("idle_busy8", busy8, 0);

    // Back-to-back with start held high.
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back('{so: 16'h0002, co: 1'b0, ovf: 1'b0, acc: cyc});
    a8 = 8'h7F; b8 = 8'h01;
    repeat (9) @(posedge clk);
    #1;
    q8.push_back('{so: 16'h0080, co: 1'b0, ovf: 1'b1, acc: cyc});
    start8 = 1'b0;
    chk("b2b_busy8", busy8, 1);
    drain(1'b0);

    // Reset 3 cycles into RUN aborts with cleared outputs.
    issue8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_so8", so8, 0);
    chk("abort_co8", co8, 0);
    chk("abort_ovf8", ovf8, 0);
    issue8(8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    drain(1'b0);
    repeat (10) @(posedge clk);
    #1;

    // 16-bit, 4 bits per cycle.
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain(1'b1);
    issue16(16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    drain(1'b1);
    issue16(16'h7FF0, 16'h0010, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain(1'b1);
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
